// File: rtl/rlbp_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rlbp_wb_pkg
// Purpose  : Shared definitions for the rlbp Wishbone arbiter and the future
//            logic-analyzer bridge: FSM state encodings, owner indices and
//            default bus widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rlbp_wb_pkg;

  // Arbiter ownership states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  // Owner indices, as stored in the last-owner register
  localparam logic c_OWNER_M0 = 1'b0;
  localparam logic c_OWNER_M1 = 1'b1;

  // Default Wishbone widths
  localparam int c_DEFAULT_AW = 32;
  localparam int c_DEFAULT_DW = 32;

endpackage : rlbp_wb_pkg
`default_nettype wire

// File: rtl/rlbp_wb_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : rlbp_wb_watchdog
// Purpose  : Stuck-slave timeout counter for the rlbp Wishbone arbiter.
//            Counts cycles a strobe waits for ack; flags expiry when the count
//            reaches TIMEOUT_CYCLES.
// Ports    : clk      - system clock
//            rst      - asynchronous active-high reset
//            i_clear  - clear the count (no owner, or slave ack)
//            i_inc    - a strobe is waiting for ack this cycle
//            o_expire - count has reached TIMEOUT_CYCLES
// Revision : 1.0 - initial release
// ============================================================================
module rlbp_wb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expire
);

  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);

  logic [c_CNT_W-1:0] r_count;

  assign o_expire = (r_count == c_LIMIT);

  // Saturates at the limit; the arbiter leaves the owned state on expiry,
  // which clears the count on the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && !o_expire) begin
      r_count <= r_count + c_CNT_W'(1);
    end
  end

endmodule : rlbp_wb_watchdog
`default_nettype wire

// File: rtl/rlbp_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rlbp_wb_arbiter
// Purpose  : Two-master / one-slave Wishbone arbiter sharing the rlbp_macro
//            slave port. Master 0 = management SoC bus, master 1 = LA bridge.
//            Round-robin on ties, grant held for the whole cyc burst, at least
//            one idle cycle between grants.
// Config   : `define RLBP_WB_ARB_TIMEOUT_EN to build the stuck-slave watchdog
//            (error pulse + forced bus release after TIMEOUT_CYCLES waits).
// Ports    : wb_clk_i / wb_rst_i        - clock, async active-high reset
//            mN_cyc/stb/we/sel/adr/dat_i - master N request (N = 0,1)
//            mN_dat_o / mN_ack_o / mN_err_o - master N response
//            s_cyc/stb/we/sel/adr/dat_o  - slave request
//            s_dat_i / s_ack_i           - slave response
//            grant_o                     - one-hot owner, 00 = idle
// Revision : 1.0 - initial release
// ============================================================================
module rlbp_wb_arbiter
  import rlbp_wb_pkg::*;
#(
  parameter int AW             = c_DEFAULT_AW,
  parameter int DW             = c_DEFAULT_DW,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  // master 0
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  // master 1
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  // slave
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  // status
  output logic [1:0]      grant_o
);

  // Elaboration-time sanity check on the watchdog threshold.
  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("rlbp_wb_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_t r_state;
  state_t w_state_nxt;
  logic   r_last_owner;
  logic   w_last_owner_nxt;

  logic   w_req0;      // master 0 eligible for a grant
  logic   w_req1;      // master 1 eligible for a grant
  logic   w_expire;    // watchdog abort of the current owner

`ifdef RLBP_WB_ARB_TIMEOUT_EN
  logic       w_wd_expire;
  logic       w_wd_inc;
  logic       w_wd_clear;
  logic [1:0] r_block;   // master aborted by the watchdog, still holding cyc

  // A strobe is waiting whenever the owner's request reaches the slave
  // without an ack in this cycle.
  assign w_wd_inc   = (((r_state == ST_OWN0) && m0_cyc_i && m0_stb_i) ||
                       ((r_state == ST_OWN1) && m1_cyc_i && m1_stb_i)) && !s_ack_i;
  // Holding the count at zero while idle clears it on every new grant.
  assign w_wd_clear = (r_state == ST_IDLE) || s_ack_i;
  assign w_expire   = w_wd_expire && (r_state != ST_IDLE);

  rlbp_wb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .i_clear  (w_wd_clear),
    .i_inc    (w_wd_inc),
    .o_expire (w_wd_expire)
  );

  // An aborted master may not be re-granted until it has dropped cyc for
  // at least one clock edge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_block <= 2'b00;
    end else begin
      r_block[0] <= (w_expire && (r_state == ST_OWN0)) ? 1'b1 : (r_block[0] && m0_cyc_i);
      r_block[1] <= (w_expire && (r_state == ST_OWN1)) ? 1'b1 : (r_block[1] && m1_cyc_i);
    end
  end

  assign w_req0 = m0_cyc_i && !r_block[0];
  assign w_req1 = m1_cyc_i && !r_block[1];
`else
  assign w_expire = 1'b0;
  assign w_req0   = m0_cyc_i;
  assign w_req1   = m1_cyc_i;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state      <= ST_IDLE;
      r_last_owner <= c_OWNER_M1;   // master 0 wins the first tie
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_owner_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Grants are only issued from IDLE, so every handover
  // passes through at least one idle cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_last_owner_nxt = r_last_owner;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req0 && (!w_req1 || (r_last_owner == c_OWNER_M1))) begin
          w_state_nxt      = ST_OWN0;
          w_last_owner_nxt = c_OWNER_M0;
        end else if (w_req1) begin
          w_state_nxt      = ST_OWN1;
          w_last_owner_nxt = c_OWNER_M1;
        end
      end
      ST_OWN0: begin
        if (!m0_cyc_i || w_expire) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OWN1: begin
        if (!m1_cyc_i || w_expire) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Bus mux. Everything is zero while idle; acks are qualified by the owner's
  // live cyc and stb so a stale slave ack never reaches a master.
  // --------------------------------------------------------------------------
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    unique case (r_state)
      ST_OWN0: begin
        s_cyc_o  = m0_cyc_i && !w_expire;
        s_stb_o  = m0_cyc_i && m0_stb_i && !w_expire;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i && m0_cyc_i && m0_stb_i && !w_expire;
        m0_err_o = w_expire;
      end
      ST_OWN1: begin
        s_cyc_o  = m1_cyc_i && !w_expire;
        s_stb_o  = m1_cyc_i && m1_stb_i && !w_expire;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i && m1_cyc_i && m1_stb_i && !w_expire;
        m1_err_o = w_expire;
      end
      default: begin
      end
    endcase
  end

  assign grant_o = {(r_state == ST_OWN1), (r_state == ST_OWN0)};

endmodule : rlbp_wb_arbiter
`default_nettype wire

// File: tb/tb_rlbp_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rlbp_wb_arbiter
// Purpose  : Directed self-checking bench for rlbp_wb_arbiter. Inputs change
//            1 time unit after the rising edge, outputs are checked 1 unit
//            later. The watchdog scenario follows RLBP_WB_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rlbp_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we;
  logic [3:0]  m0_sel;
  logic [31:0] m0_adr, m0_wdat, m0_rdat;
  logic        m0_ack, m0_err;
  logic        m1_cyc, m1_stb, m1_we;
  logic [3:0]  m1_sel;
  logic [31:0] m1_adr, m1_wdat, m1_rdat;
  logic        m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic        s_ack;
  logic [1:0]  grant;

  int n_cmp = 0;
  int n_err = 0;

  rlbp_wb_arbiter #(
    .AW             (32),
    .DW             (32),
    .TIMEOUT_CYCLES (8)
  ) u_dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m0_cyc_i (m0_cyc),
    .m0_stb_i (m0_stb),
    .m0_we_i  (m0_we),
    .m0_sel_i (m0_sel),
    .m0_adr_i (m0_adr),
    .m0_dat_i (m0_wdat),
    .m0_dat_o (m0_rdat),
    .m0_ack_o (m0_ack),
    .m0_err_o (m0_err),
    .m1_cyc_i (m1_cyc),
    .m1_stb_i (m1_stb),
    .m1_we_i  (m1_we),
    .m1_sel_i (m1_sel),
    .m1_adr_i (m1_adr),
    .m1_dat_i (m1_wdat),
    .m1_dat_o (m1_rdat),
    .m1_ack_o (m1_ack),
    .m1_err_o (m1_err),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_we_o   (s_we),
    .s_sel_o  (s_sel),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_wdat),
    .s_dat_i  (s_rdat),
    .s_ack_i  (s_ack),
    .grant_o  (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL tb_time_limit: run did not finish, got timeout, expected $finish");
    $fatal(1, "time limit");
  end

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_val({tag, "_ctrl"}, 64'({grant, s_cyc, s_stb, s_we, s_sel, m0_ack, m1_ack, m0_err, m1_err}), 64'd0);
    chk_val({tag, "_sadr_sdat"}, {s_adr, s_wdat}, 64'd0);
    chk_val({tag, "_mdat"}, {m0_rdat, m1_rdat}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 0; m0_adr = 0; m0_wdat = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 0; m1_adr = 0; m1_wdat = 0;
    s_ack = 0; s_rdat = 32'hA5A5_A5A5;
    #2;
    chk_all_zero("reset");
    step(); step();
    rst = 1'b0;

    // ---------------- single-master write ----------------
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF;
    m0_adr = 32'h3000_0004; m0_wdat = 32'hDEAD_BEEF;
    #1;
    chk_val("t1_latency_grant", 64'(grant), 64'd0);
    chk_val("t1_latency_scyc", 64'(s_cyc), 64'd0);
    step();
    chk_val("t1_grant", 64'(grant), 64'd1);
    chk_val("t1_scyc_sstb_swe", 64'({s_cyc, s_stb, s_we}), 64'h7);
    chk_val("t1_sadr", 64'(s_adr), 64'h3000_0004);
    chk_val("t1_sdat", 64'(s_wdat), 64'hDEAD_BEEF);
    chk_val("t1_ssel", 64'(s_sel), 64'hF);
    chk_val("t1_m0ack_noack", 64'(m0_ack), 64'd0);
    s_ack = 1;
    #1;
    chk_val("t1_m0ack", 64'(m0_ack), 64'd1);
    chk_val("t1_m1ack", 64'(m1_ack), 64'd0);
    chk_val("t1_m0rdat", 64'(m0_rdat), 64'hA5A5_A5A5);
    chk_val("t1_m1rdat", 64'(m1_rdat), 64'd0);
    step();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    #1;
    chk_val("t1_drop_scyc", 64'(s_cyc), 64'd0);
    chk_val("t1_drop_grant", 64'(grant), 64'd1);
    step();
    chk_val("t1_idle_grant", 64'(grant), 64'd0);

    // ---------------- round-robin alternation ----------------
    rst = 1; #1; step(); rst = 0;
    m0_cyc = 1; m0_stb = 1; m0_we = 0;
    m1_cyc = 1; m1_stb = 1;
    step();
    begin
      logic [1:0] exp_g;
      exp_g = 2'b01;
      for (int r = 0; r < 4; r++) begin
        chk_val($sformatf("t2_grant_r%0d", r), 64'(grant), 64'(exp_g));
        if (exp_g == 2'b01) m0_cyc = 0; else m1_cyc = 0;
        step();
        chk_val($sformatf("t2_idle_r%0d", r), 64'(grant), 64'd0);
        if (exp_g == 2'b01) m0_cyc = 1; else m1_cyc = 1;
        step();
        exp_g = (exp_g == 2'b01) ? 2'b10 : 2'b01;
      end
      chk_val("t2_grant_final", 64'(grant), 64'(exp_g));
    end
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    step(); step();

    // ---------------- m1 burst while m0 waits ----------------
    // last owner is m0, so the tie goes to m1
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 0; m1_we = 0;
    step();
    chk_val("t3_grant", 64'(grant), 64'd2);
    for (int i = 0; i < 4; i++) begin
      m1_stb = 1; m1_adr = 32'h3000_0000 + 32'(4 * i);
      s_ack = 1; s_rdat = 32'((i + 1) * 32'h11);
      #1;
      chk_val($sformatf("t3_grant_b%0d", i), 64'(grant), 64'd2);
      chk_val($sformatf("t3_sadr_b%0d", i), 64'(s_adr), 64'(32'h3000_0000 + 32'(4 * i)));
      chk_val($sformatf("t3_m1ack_b%0d", i), 64'(m1_ack), 64'd1);
      chk_val($sformatf("t3_m1dat_b%0d", i), 64'(m1_rdat), 64'(32'((i + 1) * 32'h11)));
      chk_val($sformatf("t3_m0side_b%0d", i), 64'({m0_ack, m0_rdat}), 64'd0);
      step();
      m1_stb = 0; s_ack = 0;
      #1;
      chk_val($sformatf("t3_gap_grant_b%0d", i), 64'(grant), 64'd2);
      step();
    end
    m1_cyc = 0;
    #1;
    chk_val("t3_drop_scyc", 64'(s_cyc), 64'd0);
    step();
    chk_val("t3_idle_grant", 64'(grant), 64'd0);
    step();
    chk_val("t3_m0_grant", 64'(grant), 64'd1);

    // ---------------- reset mid-transfer ----------------
    s_rdat = 32'h5A5A_5A5A; m1_cyc = 1; m1_stb = 1;
    #1;
    chk_val("t4_pre_sstb", 64'(s_stb), 64'd1);
    rst = 1; s_ack = 1;
    #1;
    chk_all_zero("t4_reset");
    step();
    rst = 0; s_ack = 0;
    step();
    // m0 was the last owner before reset, so only a restored preference
    // lets it win this tie
    chk_val("t4_tie_grant", 64'(grant), 64'd1);

    // ---------------- stale acks ----------------
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    step();
    chk_val("t5_idle_grant", 64'(grant), 64'd0);
    s_ack = 1;
    #1;
    chk_val("t5_idle_acks", 64'({m0_ack, m1_ack, s_cyc}), 64'd0);
    s_ack = 0; m0_cyc = 1; m0_stb = 1;
    step();
    chk_val("t5_grant", 64'(grant), 64'd1);
    m0_cyc = 0; m0_stb = 0; s_ack = 1;
    #1;
    chk_val("t5_dropped_ack", 64'({m0_ack, s_stb}), 64'd0);
    step();
    chk_val("t5_after_ack", 64'({grant, m0_ack, m1_ack}), 64'd0);
    s_ack = 0;

`ifdef RLBP_WB_ARB_TIMEOUT_EN
    // ---------------- watchdog abort ----------------
    m0_cyc = 1; m0_stb = 1;
    step();
    chk_val("t6_grant", 64'(grant), 64'd1);
    m1_cyc = 1; m1_stb = 1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk_val($sformatf("t6_wait_err_%0d", k), 64'({m0_err, s_cyc}), 64'b01);
      step();
    end
    chk_val("t6_err", 64'(m0_err), 64'd1);
    chk_val("t6_forced_low", 64'({s_cyc, s_stb}), 64'd0);
    chk_val("t6_grant_held", 64'(grant), 64'd1);
    chk_val("t6_m1err", 64'(m1_err), 64'd0);
    m0_cyc = 0; m0_stb = 0;
    step();
    chk_val("t6_idle", 64'({grant, m0_err}), 64'd0);
    step();
    chk_val("t6_m1_grant", 64'(grant), 64'd2);
`else
    // ---------------- no watchdog: wait indefinitely ----------------
    m0_cyc = 1; m0_stb = 1;
    step();
    m1_cyc = 1; m1_stb = 1;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk_val($sformatf("t6_hold_%0d", k), 64'({grant, m0_err, s_stb}), 64'b0101);
      step();
    end
    m0_cyc = 0; m0_stb = 0;
    step();
    chk_val("t6_idle", 64'(grant), 64'd0);
    step();
    chk_val("t6_m1_grant", 64'(grant), 64'd2);
`endif
    m1_cyc = 0; m1_stb = 0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rlbp_wb_arbiter
`default_nettype wire

// File: doc/rlbp_wb_arbiter.md
Name: rlbp_wb_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares the rlbp_macro Wishbone slave port inside user_project_wrapper.
- Master 0 is the Caravel management SoC bus (wbs_*). Master 1 is a logic-analyzer-driven bridge used for bring-up.
- Round-robin grant. A grant is held for the whole cyc burst. Optional stuck-slave watchdog returns an error and frees the bus.

Parameters:
- AW, 32, address width
- DW, 32, data width (SEL width = DW/8)
- TIMEOUT_CYCLES, 255, cycles stb may wait for ack before abort (used only with the watchdog)

Ports:
- wb_clk_i  in  1  single system clock
- wb_rst_i  in  1  asynchronous, active-high reset
- mN_cyc_i  in  1  master N bus cycle (N = 0,1; same for all mN_ lines)
- mN_stb_i  in  1  master N strobe
- mN_we_i  in  1  master N write enable
- mN_sel_i  in  DW/8  master N byte selects
- mN_adr_i  in  AW  master N address
- mN_dat_i  in  DW  master N write data
- mN_dat_o  out  DW  read data to master N
- mN_ack_o  out  1  ack to master N
- mN_err_o  out  1  error (timeout) to master N
- s_cyc_o, s_stb_o, s_we_o  out  1  slave control
- s_sel_o  out  DW/8  slave byte selects
- s_adr_o  out  AW  slave address
- s_dat_o  out  DW  slave write data
- s_dat_i  in  DW  slave read data
- s_ack_i  in  1  slave ack
- grant_o  out  2  one-hot current owner (bit N = master N); 00 = idle

Behaviour:
- State machine states: IDLE, OWN0, OWN1. The state register updates only on the wb_clk_i rising edge or on wb_rst_i.
- Reset (asynchronous, immediate):
  - state = IDLE, last_owner = 1 (so master 0 wins the first tie).
  - Every output is 0: all s_* outputs, mN_ack_o, mN_err_o, mN_dat_o, grant_o.
- IDLE:
  - Only m0_cyc_i high -> OWN0. Only m1_cyc_i high -> OWN1.
  - Both high -> grant the master that is not last_owner.
  - On entering OWNn, last_owner is set to n.
  - Arbitration latency: exactly 1 cycle from cyc_i high in IDLE to s_cyc_o high.
- OWNn, slave side:
  - s_cyc_o = mn_cyc_i; s_stb_o = mn_cyc_i & mn_stb_i.
  - s_we_o, s_sel_o, s_adr_o, s_dat_o are combinationally muxed from master n.
- OWNn, master side:
  - mn_ack_o = s_ack_i & mn_stb_i; mn_dat_o = s_dat_i.
  - The non-owner sees ack = 0, err = 0, dat_o = 0.
- Leaving OWNn:
  - mn_cyc_i low at a clock edge -> IDLE.
  - At least one IDLE cycle always separates two grants (no back-to-back handover).
  - The other master's pending cyc is granted on the following edge.
- In IDLE, all s_* outputs are 0 and s_ack_i is ignored: no ack reaches any master.
- Multi-beat and pipelined bursts: stb may toggle while cyc stays high and the grant is held. There is no preemption, even if the other master waits indefinitely.
- A master dropping cyc mid-transfer (stb high, no ack yet): s_cyc_o/s_stb_o follow low combinationally. A later stale s_ack_i is not forwarded.
- Reset mid-burst: outputs go to 0 at once; the arbiter restarts in IDLE with master 0 preferred.
- grant_o mirrors the state combinationally: IDLE = 00, OWN0 = 01, OWN1 = 10.

Optional Feature:
- Macro: RLBP_WB_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on each grant and on each s_ack_i.
  - It increments while s_stb_o is high and s_ack_i is low.
  - When the count reaches TIMEOUT_CYCLES, mn_err_o pulses for 1 cycle, s_cyc_o/s_stb_o are forced low in that same cycle, and the state goes to IDLE.
  - The master must drop cyc. Re-entry is allowed only after that master's cyc has been low for at least 1 cycle.
- Without the macro: mN_err_o is tied to 0, no counter is synthesized, and the arbiter waits indefinitely for ack.

Decomposition:
- Shared include/package rlbp_wb_pkg holds:
  - state encodings (ST_IDLE = 2'd0, ST_OWN0 = 2'd1, ST_OWN1 = 2'd2);
  - owner index constants;
  - default AW/DW localparams, reused by the future LA bridge.
- One sub-module is natural: rlbp_wb_watchdog. It holds the timeout counter and its clear/inc/expire logic and is instantiated only under RLBP_WB_ARB_TIMEOUT_EN.
- The mux and the FSM stay in the top module.

Test Plan:
- Single master: m0 writes 0xDEADBEEF to 0x3000_0004 with sel = 0xF while m1 is idle. Required: grant_o = 01 one cycle after cyc; slave sees identical adr/dat/sel; m0_ack_o on the s_ack_i cycle; m1_ack_o stays 0.
- Simultaneous request: m0 and m1 raise cyc in the same cycle just after reset. Required: m0 is served first. After m0 drops cyc: 1 IDLE cycle, then grant_o = 10. Next tie -> m0 again (alternation holds over 4 rounds).
- Burst hold: m1 performs 4 reads from 0x3000_0000 to 0x3000_000C with cyc held high while m0 requests. Required: grant stays 10 for all 4 acks with data 0x11, 0x22, 0x33, 0x44 returned to m1; m0 is granted only after m1 drops cyc.
- Reset mid-transfer: assert wb_rst_i while OWN0 with stb high. Required: all outputs are 0 within the same timestep; after release, the first tie is won by m0.
- Stale ack: slave asserts s_ack_i in IDLE, and again after the owner drops cyc. Required: no mN_ack_o pulse.
- Timeout (with RLBP_WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): m0 strobes and the slave never acks. Required: m0_err_o high for exactly 1 cycle after 8 waiting cycles; s_cyc_o low in that cycle; grant_o = 00 on the next cycle; a pending m1 request is then granted.
